id_ex_stage: RTL and testbench

- ID/EX pipeline boundary, directly downstream of the decode control unit.
- Registers the decoded control bundle (reg_write_en, ALUSrc, MemtoReg, MemRead, MemWrite, alu_op) together with the operands, immediate and register indices for the EX stage.
- Contains load-use hazard detection: drives a stall to IF/ID and PC, and inserts a bubble into EX.
- Supports a flush from branch resolution and keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/alu_pkg.sv | 18 +
 rtl/pipe_pkg.sv | 25 ++
 rtl/load_use_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU operation codes shared by decode, ID/EX and the EX-stage ALU.
// ALU_ADD doubles as the neutral opcode carried by pipeline bubbles.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/pipe_pkg.sv
// Pipeline-boundary types: the ID/EX control bundle and its bubble value.
// Register x0 is hard-wired zero and never a hazard source.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write_en;
        logic       ALUSrc;
        logic       MemtoReg;
        logic       MemRead;
        logic       MemWrite;
        logic [3:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        reg_write_en: 1'b0,
        ALUSrc:       1'b0,
        MemtoReg:     1'b0,
        MemRead:      1'b0,
        MemWrite:     1'b0,
        alu_op:       alu_pkg::ALU_ADD
    };

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a load in EX whose rd is read by the instruction in ID.
// Purely combinational; flush gating is applied by the caller.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_load;

    assign ex_load = ex_valid & ex_MemRead & (ex_rd != REG_X0);
    assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
    assign hazard  = id_valid & ex_load & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and a saturating
// stall-cycle counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             reg_write_en,
    input  logic             ALUSrc,
    input  logic             MemtoReg,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [3:0]       alu_op,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write_en,
    output logic             ex_ALUSrc,
    output logic             ex_MemtoReg,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic [3:0]       ex_alu_op,
    output logic [CNT_W-1:0] stall_count
);

    id_ex_ctrl_t ex_ctrl;
    id_ex_ctrl_t cap_ctrl;
    logic        hazard;
    logic        kill;

    load_use_detect u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_MemRead  (ex_ctrl.MemRead),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    assign stall = hazard & ~flush;
    assign kill  = flush | hazard;

    // An empty ID slot still flows through, but may never write state.
    always_comb begin
        cap_ctrl = '{
            reg_write_en: reg_write_en,
            ALUSrc:       ALUSrc,
            MemtoReg:     MemtoReg,
            MemRead:      MemRead,
            MemWrite:     MemWrite,
            alu_op:       alu_op
        };
        if (!id_valid) begin
            cap_ctrl.reg_write_en = 1'b0;
            cap_ctrl.ALUSrc       = 1'b0;
            cap_ctrl.MemtoReg     = 1'b0;
            cap_ctrl.MemRead      = 1'b0;
            cap_ctrl.MemWrite     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= REG_X0;
            ex_rs2      <= REG_X0;
            ex_rd       <= REG_X0;
            ex_ctrl     <= CTRL_BUBBLE;
        end else if (kill) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= REG_X0;
            ex_rs2      <= REG_X0;
            ex_rd       <= REG_X0;
            ex_ctrl     <= CTRL_BUBBLE;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= cap_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_reg_write_en = ex_ctrl.reg_write_en;
    assign ex_ALUSrc       = ex_ctrl.ALUSrc;
    assign ex_MemtoReg     = ex_ctrl.MemtoReg;
    assign ex_MemRead      = ex_ctrl.MemRead;
    assign ex_MemWrite     = ex_ctrl.MemWrite;
    assign ex_alu_op       = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a slot-level reference model.
// A second instance with a 4-bit counter exercises saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic        reg_write_en, ALUSrc, MemtoReg, MemRead, MemWrite;
    logic [3:0]  alu_op;

    logic        stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write_en, ex_ALUSrc, ex_MemtoReg;
    logic        ex_MemRead, ex_MemWrite;
    logic [3:0]  ex_alu_op;
    logic [15:0] stall_count;

    logic        s4_stall, s4_valid;
    logic [31:0] s4_pc, s4_d1, s4_d2, s4_imm;
    logic [4:0]  s4_rs1, s4_rs2, s4_rd;
    logic        s4_rw, s4_as, s4_m2r, s4_mr, s4_mw;
    logic [3:0]  s4_op;
    logic [3:0]  s4_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .reg_write_en(reg_write_en), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .alu_op(alu_op), .stall(stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write_en(ex_reg_write_en), .ex_ALUSrc(ex_ALUSrc),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_alu_op(ex_alu_op),
        .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .reg_write_en(reg_write_en), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .alu_op(alu_op), .stall(s4_stall), .ex_valid(s4_valid),
        .ex_pc(s4_pc), .ex_rs1_data(s4_d1),
        .ex_rs2_data(s4_d2), .ex_imm(s4_imm),
        .ex_rs1(s4_rs1), .ex_rs2(s4_rs2), .ex_rd(s4_rd),
        .ex_reg_write_en(s4_rw), .ex_ALUSrc(s4_as),
        .ex_MemtoReg(s4_m2r), .ex_MemRead(s4_mr),
        .ex_MemWrite(s4_mw), .ex_alu_op(s4_op),
        .stall_count(s4_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the EX slot: what instruction sits there now.
    typedef struct {
        bit          valid;
        logic [31:0] pc, d1, d2, imm;
        int          rs1, rs2, rd;
        bit          rw, as, m2r, mr, mw;
        int          op;
    } slot_t;

    slot_t m;
    int    m_cnt16;
    int    m_cnt4;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.pc = 0; s.d1 = 0; s.d2 = 0; s.imm = 0;
        s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.rw = 0; s.as = 0; s.m2r = 0; s.mr = 0; s.mw = 0;
        s.op = 0;
        return s;
    endfunction

    // The ID instruction reads a register a load in EX has not produced yet.
    function automatic bit model_hazard();
        bit reads;
        if (!id_valid || !m.valid || !m.mr || m.rd == 0) return 0;
        reads = (id_uses_rs1 && int'(id_rs1) == m.rd) ||
                (id_uses_rs2 && int'(id_rs2) == m.rd);
        return reads;
    endfunction

    function automatic void model_advance(input bit haz);
        if (haz && !flush) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush || haz) begin
            m = empty_slot();
        end else begin
            m.valid = id_valid;
            m.pc = id_pc; m.d1 = id_rs1_data;
            m.d2 = id_rs2_data; m.imm = id_imm;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.rw  = id_valid && reg_write_en;
            m.as  = id_valid && ALUSrc;
            m.m2r = id_valid && MemtoReg;
            m.mr  = id_valid && MemRead;
            m.mw  = id_valid && MemWrite;
            m.op  = alu_op;
        end
    endfunction

    task automatic compare_all();
        check("ex_valid", ex_valid, m.valid);
        check("ex_pc", ex_pc, m.pc);
        check("ex_rs1_data", ex_rs1_data, m.d1);
        check("ex_rs2_data", ex_rs2_data, m.d2);
        check("ex_imm", ex_imm, m.imm);
        check("ex_rs1", ex_rs1, m.rs1);
        check("ex_rs2", ex_rs2, m.rs2);
        check("ex_rd", ex_rd, m.rd);
        check("ex_ctrl",
              {ex_reg_write_en, ex_ALUSrc, ex_MemtoReg,
               ex_MemRead, ex_MemWrite},
              {m.rw, m.as, m.m2r, m.mr, m.mw});
        check("ex_alu_op", ex_alu_op, m.op);
        check("stall_count", stall_count, m_cnt16);
        check("stall_count4", s4_count, m_cnt4);
    endtask

    // Called at a negedge with ID inputs applied; ends at the next negedge.
    task automatic step();
        bit haz;
        #1;
        haz = model_hazard();
        check("stall", stall, haz && !flush);
        check("stall4", s4_stall, haz && !flush);
        @(posedge clk);
        #1;
        model_advance(haz);
        compare_all();
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int pc,
                          input int rs1, input int rs2, input int rd,
                          input bit u1, input bit u2, input int imm,
                          input bit rw, input bit as, input bit m2r,
                          input bit mr, input bit mw);
        id_valid = v; id_pc = pc;
        id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0]; id_rd = rd[4:0];
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_imm = imm;
        id_rs1_data = $urandom; id_rs2_data = $urandom;
        reg_write_en = rw; ALUSrc = as; MemtoReg = m2r;
        MemRead = mr; MemWrite = mw; alu_op = 4'd0;
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 9) != 0);
        flush = ($urandom_range(0, 9) == 0);
        id_pc = $urandom; id_imm = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        id_rd  = 5'($urandom_range(0, 3));
        id_uses_rs1 = $urandom_range(0, 1);
        id_uses_rs2 = $urandom_range(0, 1);
        reg_write_en = $urandom_range(0, 1);
        ALUSrc = $urandom_range(0, 1);
        MemtoReg = $urandom_range(0, 1);
        MemRead = $urandom_range(0, 1);
        MemWrite = $urandom_range(0, 1);
        alu_op = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        rand_id();
        flush = 1'b0;
        m = empty_slot();
        m_cnt16 = 0;
        m_cnt4 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_id();
            step();
        end

        // Asynchronous reset in the middle of a cycle.
        rand_id();
        #2 rst = 1'b1;
        #1;
        m = empty_slot();
        m_cnt16 = 0;
        m_cnt4 = 0;
        compare_all();
        check("rst_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;

        // addi x5,x1,7 at pc 0x10
        set_id(1, 'h10, 1, 0, 5, 1, 0, 7, 1, 1, 0, 0, 0);
        step();
        check("addi_valid", ex_valid, 1'b1);
        check("addi_rd", ex_rd, 5'd5);
        check("addi_imm", ex_imm, 32'd7);
        check("addi_pc", ex_pc, 32'h10);

        // lw x5 then add x6,x5,x2: one stall cycle, then advance
        set_id(1, 'h14, 1, 0, 5, 1, 0, 0, 1, 1, 1, 1, 0);
        step();
        set_id(1, 'h18, 5, 2, 6, 1, 1, 0, 1, 0, 0, 0, 0);
        c0 = stall_count;
        #1 check("lu_stall", stall, 1'b1);
        step();
        check("lu_bubble_v", ex_valid, 1'b0);
        check("lu_bubble_rw", ex_reg_write_en, 1'b0);
        check("lu_count", stall_count, 16'(c0 + 1));
        #1 check("lu_release", stall, 1'b0);
        step();
        check("lu_adv_rs1", ex_rs1, 5'd5);
        check("lu_adv_v", ex_valid, 1'b1);

        // lw x0 then add x6,x0,x2
        set_id(1, 'h20, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0);
        step();
        set_id(1, 'h24, 0, 2, 6, 1, 1, 0, 1, 0, 0, 0, 0);
        #1 check("x0_stall", stall, 1'b0);
        step();

        // lw x5 then addi x6,x7,1 with rs2=5 unused
        set_id(1, 'h28, 1, 0, 5, 1, 0, 0, 1, 1, 1, 1, 0);
        step();
        set_id(1, 'h2c, 7, 5, 6, 1, 0, 1, 1, 1, 0, 0, 0);
        #1 check("unused_stall", stall, 1'b0);
        step();

        // store after load on rs2 stalls
        set_id(1, 'h30, 1, 0, 5, 1, 0, 0, 1, 1, 1, 1, 0);
        step();
        set_id(1, 'h34, 2, 5, 0, 1, 1, 4, 0, 1, 0, 0, 1);
        #1 check("st_stall", stall, 1'b1);
        step();
        step();

        // flush beats a live load-use hazard
        set_id(1, 'h40, 1, 0, 5, 1, 0, 0, 1, 1, 1, 1, 0);
        step();
        set_id(1, 'h44, 5, 2, 6, 1, 1, 0, 1, 0, 0, 0, 0);
        flush = 1'b1;
        c0 = stall_count;
        #1 check("fl_stall", stall, 1'b0);
        step();
        check("fl_valid", ex_valid, 1'b0);
        check("fl_count", stall_count, 16'(c0));
        flush = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rand_id();
            step();
        end
        flush = 1'b0;

        // lw x5,0(x5) repeated: stalls every other cycle
        set_id(1, 'h80, 5, 0, 5, 1, 0, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 42; i++) step();
        check("sat_count4", s4_count, 4'd15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
